fram_bus_bridge: RTL and testbench



---
 rtl/fram_bus_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_fram_bus_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fram_bus_bridge.sv
// ---------------------------------------------------------------------------
// fram_bus_bridge
//
// Turns single-beat bus word accesses into one-cycle read/write request
// pulses for the SPI FRAM controller. Partial-byte writes are done as a
// read-modify-write. A one-word read buffer serves repeat reads without an
// FRAM access. Every FRAM transaction is bounded by a completion timeout.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   bus_req           request strobe, taken only while idle and not busy
//   bus_we            1 = write, 0 = read
//   bus_addr[15:0]    byte address, bits [1:0] ignored
//   bus_wdata[31:0]   write data
//   bus_be[3:0]       byte enables, bit n covers bus_wdata[8n+7:8n]
//   bus_rdata[31:0]   read data, holds until the next read completes
//   bus_ready         one-cycle completion pulse
//   bus_err           set together with bus_ready when the access timed out
//   bus_busy          high from the cycle after acceptance until the cycle
//                     after bus_ready
//   mem_addr[15:0]    word-aligned FRAM byte address
//   mem_wdata[31:0]   word to write
//   mem_read_enable   one-cycle read request pulse
//   mem_write_enable  one-cycle write request pulse
//   mem_rdata[31:0]   word returned by the controller
//   mem_done          controller completion pulse
// ---------------------------------------------------------------------------
module fram_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter bit          BUF_EN         = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_be,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        bus_err,
    output logic        bus_busy,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MRG,
        WR_REQ,
        WR_WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    // Request captured at acceptance
    logic [13:0] tag_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Read half of a read-modify-write
    logic [31:0] rd_word;
    logic [31:0] merged;

    // One-word read buffer
    logic        buf_valid;
    logic [13:0] buf_tag;
    logic [31:0] buf_data;

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic accept;
    logic buf_hit;
    logic cnt_last;

    assign accept   = (state == IDLE) && !bus_busy && bus_req;
    assign buf_hit  = BUF_EN && buf_valid && (buf_tag == bus_addr[15:2]);
    assign cnt_last = (cnt == CNT_LAST);

    // Byte lanes with be set come from the bus, the others from FRAM.
    always_comb begin
        merged = rd_word;
        for (int n = 0; n < 4; n++) begin
            if (be_q[n]) begin
                merged[8*n +: 8] = wdata_q[8*n +: 8];
            end
        end
    end

    // NOTE: state_next gets its default before the case so that no path
    // leaves it unassigned; otherwise the block would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus_we) begin
                        state_next = buf_hit ? RESP : RD_REQ;
                    end else if (bus_be == 4'hF) begin
                        state_next = WR_REQ;
                    end else if (bus_be == 4'h0) begin
                        state_next = RESP;
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: begin
                // A done on the last counted cycle still completes normally.
                if (mem_done) begin
                    state_next = we_q ? MRG : RESP;
                end else if (cnt_last) begin
                    state_next = RESP;
                end
            end
            MRG:     state_next = WR_REQ;
            WR_REQ:  state_next = WR_WAIT;
            WR_WAIT: begin
                if (mem_done || cnt_last) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers are written with <= so every always_ff reads the values
    // from before the edge, regardless of block or statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control state and bus-visible outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_rdata        <= '0;
            bus_ready        <= 1'b0;
            bus_err          <= 1'b0;
            bus_busy         <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            buf_valid        <= 1'b0;
            cnt              <= '0;
            err_q            <= 1'b0;
        end else begin
            // The controller retriggers on a held level, so request strobes
            // and the completion pulse drop back every cycle.
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            bus_ready        <= 1'b0;
            bus_err          <= 1'b0;
            if (bus_ready) begin
                bus_busy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_busy <= 1'b1;
                        err_q    <= 1'b0;
                        mem_addr <= bus_addr & 16'hFFFC;
                        if (!bus_we && buf_hit) begin
                            bus_rdata <= buf_data;
                        end
                        if (bus_we && bus_be == 4'hF) begin
                            mem_wdata <= bus_wdata;
                        end
                    end
                end
                RD_REQ: begin
                    mem_read_enable <= 1'b1;
                    cnt             <= '0;
                end
                RD_WAIT: begin
                    if (mem_done) begin
                        if (!we_q) begin
                            bus_rdata <= mem_rdata;
                            if (BUF_EN) begin
                                buf_valid <= 1'b1;
                            end
                        end
                    end else if (cnt_last) begin
                        err_q     <= 1'b1;
                        buf_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MRG: begin
                    mem_wdata <= merged;
                end
                WR_REQ: begin
                    mem_write_enable <= 1'b1;
                    cnt              <= '0;
                end
                WR_WAIT: begin
                    if (!mem_done) begin
                        if (cnt_last) begin
                            err_q     <= 1'b1;
                            buf_valid <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    bus_ready <= 1'b1;
                    bus_err   <= err_q;
                end
                default: ;
            endcase
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed under
    // state or buf_valid, both of which do reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q   <= bus_addr[15:2];
            we_q    <= bus_we;
            wdata_q <= bus_wdata;
            be_q    <= bus_be;
        end
        if (state == RD_WAIT && mem_done) begin
            rd_word <= mem_rdata;
        end
        if (state == RD_WAIT && mem_done && !we_q) begin
            buf_tag  <= tag_q;
            buf_data <= mem_rdata;
        end else if (state == WR_WAIT && mem_done && buf_tag == tag_q) begin
            // Write-through keeps a buffered copy of this word coherent.
            buf_data <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_fram_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_fram_bus_bridge
//
// Self-checking bench for fram_bus_bridge with TIMEOUT_CYCLES=8. A small FRAM
// controller model answers request pulses after a programmable latency (or
// never). A table of directed accesses, hand-written busy/reset sequences and
// a randomized phase against a word-level reference model are compared.
// ---------------------------------------------------------------------------
module tb_fram_bus_bridge;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;
    logic        bus_busy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_rdata;
    logic        mem_done;

    fram_bus_bridge #(
        .TIMEOUT_CYCLES(TO),
        .BUF_EN        (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_be          (bus_be),
        .bus_rdata       (bus_rdata),
        .bus_ready       (bus_ready),
        .bus_err         (bus_err),
        .bus_busy        (bus_busy),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_rdata       (mem_rdata),
        .mem_done        (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- FRAM controller model ----------------
    logic [31:0] fram [0:16383];
    int          model_lat;      // 0: random 1..5, -1: never done, >0: fixed
    int          pending;
    logic        model_we;
    logic [13:0] model_idx;
    int          rd_pulses;
    int          wr_pulses;
    logic [15:0] last_mem_addr;
    logic [31:0] last_mem_wdata;
    bit          overlap_seen;
    bit          wide_pulse_seen;
    logic        prev_rd;
    logic        prev_wr;

    initial begin
        mem_done = 1'b0; mem_rdata = '0; pending = 0; model_we = 1'b0; model_idx = '0;
        rd_pulses = 0; wr_pulses = 0; last_mem_addr = '0; last_mem_wdata = '0;
        overlap_seen = 1'b0; wide_pulse_seen = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (!rst_n) begin
                pending = 0; prev_rd = 1'b0; prev_wr = 1'b0;
            end else begin
                if (mem_read_enable && mem_write_enable) overlap_seen = 1'b1;
                if ((mem_read_enable && prev_rd) || (mem_write_enable && prev_wr)) wide_pulse_seen = 1'b1;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        mem_done = 1'b1;
                        if (model_we) fram[model_idx] = last_mem_wdata;
                        else          mem_rdata = fram[model_idx];
                    end
                end
                if ((mem_read_enable && !prev_rd) || (mem_write_enable && !prev_wr)) begin
                    if (mem_read_enable) rd_pulses++;
                    else                 wr_pulses++;
                    model_we      = mem_write_enable;
                    model_idx     = mem_addr[15:2];
                    last_mem_addr = mem_addr;
                    if (mem_write_enable) last_mem_wdata = mem_wdata;
                    if (model_lat < 0)       pending = 0;
                    else if (model_lat == 0) pending = int'($urandom_range(1, 5));
                    else                     pending = model_lat;
                end
                prev_rd = mem_read_enable;
                prev_wr = mem_write_enable;
            end
        end
    end

    // ---------------- word-level reference model ----------------
    logic [31:0] ref_mem [0:16383];
    bit          rb_valid;
    logic [13:0] rb_tag;
    logic [31:0] rb_data;
    logic [31:0] ref_rdata;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] e_rdata;
        int          e_rd;
        int          e_wr;
        logic        e_err;
        int          e_cyc;    // -1: latency not checked
        logic [31:0] e_wword;
    } vec_t;

    function automatic vec_t mk(logic we, logic [15:0] addr, logic [31:0] wdata, logic [3:0] be, int lat,
                                logic [31:0] e_rdata, int e_rd, int e_wr, logic e_err, int e_cyc,
                                logic [31:0] e_wword);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.lat = lat;
        v.e_rdata = e_rdata; v.e_rd = e_rd; v.e_wr = e_wr; v.e_err = e_err;
        v.e_cyc = e_cyc; v.e_wword = e_wword;
        return v;
    endfunction

    // Predicts one access from the bridge's rules and advances the model.
    // A stalled access times out on its first FRAM operation: 11 clocks from
    // request to ready (2 to issue, 8 wait cycles, response).
    task automatic ref_txn(inout vec_t v, input bit stall);
        logic [13:0] idx;
        logic [31:0] w;
        idx = v.addr[15:2];
        v.e_rd = 0; v.e_wr = 0; v.e_err = 1'b0; v.e_cyc = -1; v.e_wword = '0;
        if (!v.we) begin
            if (rb_valid && rb_tag == idx) begin
                v.e_cyc = 2;
                ref_rdata = rb_data;
            end else begin
                v.e_rd = 1;
                if (stall) begin
                    v.e_err = 1'b1; v.e_cyc = 11; rb_valid = 1'b0;
                end else begin
                    ref_rdata = ref_mem[idx];
                    rb_valid = 1'b1; rb_tag = idx; rb_data = ref_mem[idx];
                end
            end
        end else if (v.be == 4'h0) begin
            v.e_cyc = 2;
        end else if (v.be != 4'hF && stall) begin
            v.e_rd = 1; v.e_err = 1'b1; v.e_cyc = 11; rb_valid = 1'b0;
        end else begin
            if (v.be != 4'hF) v.e_rd = 1;
            w = ref_mem[idx];
            for (int n = 0; n < 4; n++) if (v.be[n]) w[8*n +: 8] = v.wdata[8*n +: 8];
            v.e_wr = 1; v.e_wword = w;
            if (stall) begin
                v.e_err = 1'b1; v.e_cyc = 11; rb_valid = 1'b0;
            end else begin
                ref_mem[idx] = w;
                if (rb_valid && rb_tag == idx) rb_data = w;
            end
        end
        v.e_rdata = ref_rdata;
    endtask

    // Drives one access (called at a negedge, returns at a negedge with the
    // bridge idle) and compares it against the expectations in v.
    task automatic apply(input vec_t v, input string tag);
        int   rd0, wr0, cyc;
        bit   seen;
        logic busy1;
        logic [31:0] rdata;
        logic        err;
        model_lat = v.lat;
        rd0 = rd_pulses; wr0 = wr_pulses;
        bus_we = v.we; bus_addr = v.addr; bus_wdata = v.wdata; bus_be = v.be; bus_req = 1'b1;
        cyc = 0; seen = 1'b0; busy1 = 1'b0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus_req = 1'b0;
            if (i == 0) busy1 = bus_busy;
            if (bus_ready) begin
                seen = 1'b1; rdata = bus_rdata; err = bus_err;
            end
        end
        check({tag, ".ready_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, ".busy_after_accept"}, 32'(busy1), 32'd1);
        check({tag, ".busy_released"}, 32'(bus_busy), 32'd0);
        check({tag, ".err"}, 32'(err), 32'(v.e_err));
        check({tag, ".rd_pulses"}, 32'(rd_pulses - rd0), 32'(v.e_rd));
        check({tag, ".wr_pulses"}, 32'(wr_pulses - wr0), 32'(v.e_wr));
        if (!v.we) check({tag, ".rdata"}, rdata, v.e_rdata);
        if (v.e_cyc >= 0) check({tag, ".latency"}, 32'(cyc), 32'(v.e_cyc));
        if (v.e_rd + v.e_wr > 0) check({tag, ".mem_addr"}, 32'(last_mem_addr), 32'(v.addr & 16'hFFFC));
        if (v.e_wr > 0) check({tag, ".mem_wdata"}, last_mem_wdata, v.e_wword);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   rd0, wr0, readies;
        logic [31:0] rdv;

        for (int i = 0; i < 16384; i++) begin
            fram[i]    = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        fram[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
        fram[12] = 32'hAABBCCDD; ref_mem[12] = 32'hAABBCCDD;
        rb_valid = 1'b0; rb_tag = '0; rb_data = '0; ref_rdata = '0;
        model_lat = 0;

        //                 we addr      wdata         be    lat  e_rdata       rd wr err cyc wword
        vecs.push_back(mk(0, 16'h0010, 32'h0,        4'h0, 0,  32'hDEADBEEF, 1, 0, 0, -1, 32'h0));
        vecs.push_back(mk(0, 16'h0010, 32'h0,        4'h0, 0,  32'hDEADBEEF, 0, 0, 0,  2, 32'h0));
        vecs.push_back(mk(1, 16'h0020, 32'h12345678, 4'hF, 0,  32'h0,        0, 1, 0, -1, 32'h12345678));
        vecs.push_back(mk(0, 16'h0022, 32'h0,        4'h0, 0,  32'h12345678, 1, 0, 0, -1, 32'h0));
        vecs.push_back(mk(1, 16'h0030, 32'h11223344, 4'h5, 0,  32'h0,        1, 1, 0, -1, 32'hAA22CC44));
        vecs.push_back(mk(0, 16'h0030, 32'h0,        4'h0, 0,  32'hAA22CC44, 1, 0, 0, -1, 32'h0));
        vecs.push_back(mk(0, 16'h0030, 32'h0,        4'h0, 0,  32'hAA22CC44, 0, 0, 0,  2, 32'h0));
        vecs.push_back(mk(1, 16'h0030, 32'hFFFFFFFF, 4'h0, 0,  32'h0,        0, 0, 0,  2, 32'h0));
        vecs.push_back(mk(1, 16'h0030, 32'h99000000, 4'h8, 0,  32'h0,        1, 1, 0, -1, 32'h9922CC44));
        vecs.push_back(mk(0, 16'h0030, 32'h0,        4'h0, 0,  32'h9922CC44, 0, 0, 0,  2, 32'h0));
        vecs.push_back(mk(1, 16'h0030, 32'h55555555, 4'hF, -1, 32'h0,        0, 1, 1, 11, 32'h55555555));
        vecs.push_back(mk(0, 16'h0030, 32'h0,        4'h0, 0,  32'h9922CC44, 1, 0, 0, -1, 32'h0));
        vecs.push_back(mk(0, 16'h0040, 32'h0,        4'h0, -1, 32'h9922CC44, 1, 0, 1, 11, 32'h0));
        vecs.push_back(mk(0, 16'h0040, 32'h0,        4'h0, 0,  32'hC0DE0010, 1, 0, 0, -1, 32'h0));
        vecs.push_back(mk(1, 16'h0050, 32'h77777777, 4'h1, -1, 32'h0,        1, 0, 1, 11, 32'h0));
        vecs.push_back(mk(0, 16'h0010, 32'h0,        4'h0, 7,  32'hDEADBEEF, 1, 0, 0, -1, 32'h0));
        vecs.push_back(mk(0, 16'h0014, 32'h0,        4'h0, 8,  32'hDEADBEEF, 1, 0, 1, 11, 32'h0));
        vecs.push_back(mk(0, 16'h0010, 32'h0,        4'h0, 0,  32'hDEADBEEF, 1, 0, 0, -1, 32'h0));

        // Reset state
        rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.bus_rdata", bus_rdata, 32'h0);
        check("reset.ctrl", {27'd0, bus_ready, bus_err, bus_busy, mem_read_enable, mem_write_enable}, 32'h0);
        check("reset.mem_addr", 32'(mem_addr), 32'h0);
        check("reset.mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v, $sformatf("vec%0d", i));
            ref_txn(v, (vecs[i].lat < 0) || (vecs[i].lat >= TO));
        end

        // Request raised while busy is ignored
        model_lat = 3; rd0 = rd_pulses; wr0 = wr_pulses; readies = 0; rdv = '0;
        bus_we = 1'b0; bus_addr = 16'h0060; bus_be = 4'h0; bus_wdata = '0; bus_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_ready) begin
                readies++; rdv = bus_rdata;
            end
            case (c)
                0: bus_req = 1'b0;
                1: begin
                    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 16'h0070;
                    bus_be = 4'hF; bus_wdata = 32'h0BADF00D;
                end
                3: bus_req = 1'b0;
                default: ;
            endcase
        end
        check("busy.ready_count", 32'(readies), 32'd1);
        check("busy.rd_pulses", 32'(rd_pulses - rd0), 32'd1);
        check("busy.wr_pulses", 32'(wr_pulses - wr0), 32'd0);
        check("busy.rdata", rdv, 32'hC0DE0018);
        check("busy.fram_untouched", fram[28], 32'hC0DE001C);
        v = mk(0, 16'h0060, 32'h0, 4'h0, 3, 32'h0, 0, 0, 0, -1, 32'h0);
        ref_txn(v, 1'b0);

        // Reset while waiting for a read
        model_lat = -1;
        bus_we = 1'b0; bus_addr = 16'h0080; bus_be = 4'h0; bus_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset.bus_rdata", bus_rdata, 32'h0);
        check("midreset.ctrl", {27'd0, bus_ready, bus_err, bus_busy, mem_read_enable, mem_write_enable}, 32'h0);
        check("midreset.mem_addr", 32'(mem_addr), 32'h0);
        check("midreset.mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        readies = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_ready) readies++;
        end
        check("midreset.no_ready", 32'(readies), 32'd0);
        rb_valid = 1'b0; ref_rdata = '0;
        v = mk(0, 16'h0010, 32'h0, 4'h0, 0, 32'h0, 0, 0, 0, -1, 32'h0);
        ref_txn(v, 1'b0);
        check("midreset.fresh_expect", v.e_rdata, 32'hDEADBEEF);
        apply(v, "after_reset");

        // Randomized accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            v.wdata = $urandom;
            v.be    = 4'($urandom_range(0, 15));
            v.lat   = ($urandom_range(0, 7) == 0) ? -1 : 0;
            ref_txn(v, v.lat < 0);
            apply(v, $sformatf("rand%0d", i));
        end

        check("enables_never_together", 32'(overlap_seen), 32'd0);
        check("enables_single_cycle", 32'(wide_pulse_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
